// File: rtl/mul_wb_buffer.sv
// Writeback buffer at the tail of the multiply pipeline: queues M4 results,
// hands them to the shared register-file write port, and forwards pending values.
module mul_wb_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              m4_valid,
    input  logic [DATA_W-1:0] m4result,
    input  logic              zero,
    input  logic              overflow,
    input  logic [4:0]        dst,
    output logic              mul_stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_dst,
    output logic              wb_zero,
    input  logic              wb_ready,
    output logic              exc_valid,
    output logic [4:0]        exc_dst,
    input  logic [4:0]        fwd_dst,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);
    // Storage is sized to the full pointer range so pointers index it without truncation;
    // only the first DEPTH slots are ever used.
    localparam int SLOTS = 2 ** PTR_W;

    logic [DATA_W-1:0] data_q [SLOTS];
    logic [4:0]        dst_q  [SLOTS];
    logic [SLOTS-1:0]  zero_q;
    logic [SLOTS-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              exc_valid_q, exc_valid_d;
    logic [4:0]        exc_dst_q, exc_dst_d;
    logic              accept, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign mul_stall = (count_q == PTR_W'(DEPTH));
    assign accept    = m4_valid && !mul_stall && !flush;
    // Overflowing results and writes to $zero are consumed without taking a slot.
    assign push      = accept && !overflow && (dst != 5'd0);
    assign wb_valid  = (count_q != '0);
    assign pop       = wb_valid && wb_ready;

    assign wb_data   = wb_valid ? data_q[rd_ptr_q] : '0;
    assign wb_dst    = wb_valid ? dst_q[rd_ptr_q]  : '0;
    assign wb_zero   = wb_valid ? zero_q[rd_ptr_q] : 1'b0;
    assign exc_valid = exc_valid_q;
    assign exc_dst   = exc_dst_q;

    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        vld_d       = vld_q;
        exc_valid_d = accept && overflow;
        exc_dst_d   = (accept && overflow) ? dst : 5'd0;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            vld_d    = '0;
        end else begin
            if (pop) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = ptr_inc(rd_ptr_q);
            end
            if (push) begin
                vld_d[wr_ptr_q] = 1'b1;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            vld_q       <= '0;
            exc_valid_q <= 1'b0;
            exc_dst_q   <= 5'd0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            vld_q       <= vld_d;
            exc_valid_q <= exc_valid_d;
            exc_dst_q   <= exc_dst_d;
            if (push) begin
                data_q[wr_ptr_q] <= m4result;
                dst_q[wr_ptr_q]  <= dst;
                zero_q[wr_ptr_q] <= zero;
            end
        end
    end

    // Walk from oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_dst != 5'd0) begin
            for (int k = DEPTH; k >= 1; k--) begin
                idx = PTR_W'((int'(wr_ptr_q) + DEPTH - k) % DEPTH);
                if (vld_q[idx] && (dst_q[idx] == fwd_dst)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[idx];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= PTR_W'(DEPTH));
        end
    end
endmodule

// File: tb/tb_mul_wb_buffer.sv
// Directed bench for mul_wb_buffer (DEPTH=2): writeback order, stall, exceptions,
// $zero drops, forwarding, flush, wrap-around and reset.
module tb_mul_wb_buffer;
    logic        clk = 1'b0;
    logic        reset, flush, m4_valid, zero, overflow, wb_ready;
    logic [31:0] m4result;
    logic [4:0]  dst, fwd_dst;
    logic        mul_stall, wb_valid, wb_zero, exc_valid, fwd_hit;
    logic [31:0] wb_data, fwd_data;
    logic [4:0]  wb_dst, exc_dst;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    mul_wb_buffer #(.DATA_W(32), .DEPTH(2), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .m4_valid(m4_valid),
        .m4result(m4result), .zero(zero), .overflow(overflow), .dst(dst),
        .mul_stall(mul_stall), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_dst(wb_dst), .wb_zero(wb_zero), .wb_ready(wb_ready),
        .exc_valid(exc_valid), .exc_dst(exc_dst), .fwd_dst(fwd_dst),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance past the next rising edge, then let combinational outputs settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] r, input logic ovf);
        m4_valid = v;
        m4result = d;
        dst      = r;
        overflow = ovf;
        zero     = (d == 32'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wb_ready = 1'b0; fwd_dst = 5'd5;
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        cyc(); cyc();
        reset = 1'b0;
        #1;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_stall", 32'(mul_stall), 32'd0);
        check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        check("rst_exc", 32'(exc_valid), 32'd0);

        // Single result, one-cycle latency, popped immediately.
        wb_ready = 1'b1;
        drive(1'b1, 32'h7, 5'd5, 1'b0);
        cyc();
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        #1;
        check("t1_wb_valid", 32'(wb_valid), 32'd1);
        check("t1_wb_data", wb_data, 32'h7);
        check("t1_wb_dst", 32'(wb_dst), 32'd5);
        check("t1_fwd_hit_popcycle", 32'(fwd_hit), 32'd1);
        check("t1_fwd_data", fwd_data, 32'h7);
        cyc();
        check("t1_empty", 32'(wb_valid), 32'd0);
        check("t1_fwd_gone", 32'(fwd_hit), 32'd0);

        // Fill with backpressure, third result held off by the stall.
        wb_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd3, 1'b0);
        cyc();
        drive(1'b1, 32'hB, 5'd4, 1'b0);
        cyc();
        drive(1'b1, 32'hC, 5'd7, 1'b0);
        #1;
        check("t2_full_stall", 32'(mul_stall), 32'd1);
        check("t2_head_a", wb_data, 32'hA);
        cyc();
        check("t2_held_stall", 32'(mul_stall), 32'd1);
        check("t2_stable_data", wb_data, 32'hA);
        check("t2_stable_dst", 32'(wb_dst), 32'd3);
        wb_ready = 1'b1;
        cyc();
        check("t2_stall_drop", 32'(mul_stall), 32'd0);
        check("t2_head_b", wb_data, 32'hB);
        cyc();
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        #1;
        check("t2_head_c", wb_data, 32'hC);
        check("t2_dst_c", 32'(wb_dst), 32'd7);
        cyc();
        check("t2_drained", 32'(wb_valid), 32'd0);

        // Overflow exception pulse and dropped $zero write.
        drive(1'b1, 32'h99, 5'd9, 1'b1);
        cyc();
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        #1;
        check("t3_exc_valid", 32'(exc_valid), 32'd1);
        check("t3_exc_dst", 32'(exc_dst), 32'd9);
        check("t3_no_wb", 32'(wb_valid), 32'd0);
        cyc();
        check("t3_exc_one_cycle", 32'(exc_valid), 32'd0);
        drive(1'b1, 32'h55, 5'd0, 1'b0);
        cyc();
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        #1;
        check("t3_r0_dropped", 32'(wb_valid), 32'd0);
        check("t3_r0_no_exc", 32'(exc_valid), 32'd0);

        // Forwarding picks the youngest of two matching entries.
        wb_ready = 1'b0;
        drive(1'b1, 32'h11, 5'd6, 1'b0);
        cyc();
        drive(1'b1, 32'h22, 5'd6, 1'b0);
        cyc();
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        fwd_dst = 5'd6;
        #1;
        check("t4_fwd_hit", 32'(fwd_hit), 32'd1);
        check("t4_fwd_youngest", fwd_data, 32'h22);
        check("t4_head_oldest", wb_data, 32'h11);
        fwd_dst = 5'd0;
        #1;
        check("t4_fwd_r0", 32'(fwd_hit), 32'd0);
        check("t4_fwd_r0_data", fwd_data, 32'd0);
        fwd_dst = 5'd3;
        #1;
        check("t4_fwd_miss", 32'(fwd_hit), 32'd0);

        // Flush with the buffer full and a result presented.
        flush = 1'b1;
        drive(1'b1, 32'h33, 5'd8, 1'b0);
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        fwd_dst = 5'd6;
        #1;
        check("t5_flush_empty", 32'(wb_valid), 32'd0);
        check("t5_flush_stall", 32'(mul_stall), 32'd0);
        check("t5_flush_fwd", 32'(fwd_hit), 32'd0);
        // Flush with room available must still suppress the presented result.
        drive(1'b1, 32'h44, 5'd10, 1'b0);
        cyc();
        flush = 1'b1;
        drive(1'b1, 32'h33, 5'd8, 1'b0);
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        fwd_dst = 5'd8;
        #1;
        check("t5_flush_suppress", 32'(wb_valid), 32'd0);
        check("t5_flush_no_fwd", 32'(fwd_hit), 32'd0);
        // An exception scheduled before a flush still fires.
        drive(1'b1, 32'h1, 5'd12, 1'b1);
        cyc();
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        flush = 1'b1;
        #1;
        check("t5_exc_survives", 32'(exc_valid), 32'd1);
        check("t5_exc_dst", 32'(exc_dst), 32'd12);
        cyc();
        flush = 1'b0;
        #1;
        check("t5_exc_cleared", 32'(exc_valid), 32'd0);

        // Streaming at full throughput across several pointer wraps.
        wb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 5'(i + 1), 1'b0);
            exp_q.push_back(32'h100 + 32'(i));
            cyc();
            check("t6_stall", 32'(mul_stall), 32'd0);
            check("t6_valid", 32'(wb_valid), 32'd1);
            check("t6_data", wb_data, exp_q.pop_front());
            check("t6_dst", 32'(wb_dst), 32'(i + 1));
        end
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        cyc();
        check("t6_drained", 32'(wb_valid), 32'd0);

        // Reset mid-operation clears pending entries and exceptions.
        wb_ready = 1'b0;
        drive(1'b1, 32'h77, 5'd2, 1'b0);
        cyc();
        drive(1'b1, 32'h78, 5'd2, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0);
        fwd_dst = 5'd2;
        #1;
        check("t7_reset_wb", 32'(wb_valid), 32'd0);
        check("t7_reset_exc", 32'(exc_valid), 32'd0);
        check("t7_reset_fwd", 32'(fwd_hit), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
